bus_select_encoder: RTL and testbench



---
 rtl/bus_pkg.sv | 43 ++++
 rtl/priority_encoder_32.sv | 28 ++
 rtl/bus_select_encoder.sv | 83 ++++++++
 tb/tb_bus_select_encoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 32-source datapath bus: widths, implemented-source
// mask, select-encoder state encoding and named source indices.
package bus_pkg;

    localparam int unsigned NUM_SRC = 32;
    localparam int unsigned SEL_W   = 5;

    // Bits 0-23 and 25 are wired to real bus drivers.
    localparam logic [NUM_SRC-1:0] DEFAULT_VALID_MASK = 32'h02FF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LOCKED
    } bus_state_t;

    localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
    localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
    localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
    localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
    localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
    localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
    localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
    localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
    localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
    localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
    localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
    localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
    localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
    localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
    localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
    localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
    localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
    localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [SEL_W-1:0] SRC_IR     = 5'd23;
    localparam logic [SEL_W-1:0] SRC_IMM    = 5'd25;

endpackage

// File: rtl/priority_encoder_32.sv
// Combinational fixed-priority encoder: lowest set bit wins, plus any/multi flags.
module priority_encoder_32
    import bus_pkg::*;
(
    input  logic [NUM_SRC-1:0] eff,
    output logic [SEL_W-1:0]   index,
    output logic               any,
    output logic               multi
);

    logic found;

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eff[i] && !found) begin
                index = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

    assign any = |eff;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(eff & (eff - NUM_SRC'(1)));

endmodule

// File: rtl/bus_select_encoder.sv
// Registers the priority-encoded bus select from one-hot drive requests, with
// hold-based locking, conflict reporting and unimplemented-source detection.
module bus_select_encoder
    import bus_pkg::*;
#(
    parameter logic [NUM_SRC-1:0] VALID_MASK = DEFAULT_VALID_MASK,
    parameter int unsigned        CNT_W      = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] out_en,
    input  logic               hold,
    input  logic               conflict_ack,
    output logic [SEL_W-1:0]   select,
    output logic               select_valid,
    output logic [NUM_SRC-1:0] grant,
    output logic               conflict,
    output logic               conflict_sticky,
    output logic               bad_req,
    output logic [CNT_W-1:0]   conflict_count
);

    bus_state_t         state;
    logic [NUM_SRC-1:0] eff;
    logic [SEL_W-1:0]   win_index;
    logic               win_any;
    logic               win_multi;
    logic               arbitrate;
    logic               conflict_ev;

    assign eff = out_en & VALID_MASK;

    priority_encoder_32 u_penc (
        .eff   (eff),
        .index (win_index),
        .any   (win_any),
        .multi (win_multi)
    );

    // IDLE ignores hold; DRIVE and LOCKED arbitrate only once hold is low.
    always_comb begin
        arbitrate   = (state == IDLE) || !hold;
        conflict_ev = arbitrate && win_multi;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state           <= IDLE;
            select          <= '0;
            select_valid    <= 1'b0;
            grant           <= '0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            bad_req         <= 1'b0;
            conflict_count  <= '0;
        end else begin
            bad_req  <= |(out_en & ~VALID_MASK);
            conflict <= conflict_ev;

            if (conflict_ev)
                conflict_sticky <= 1'b1;
            else if (conflict_ack)
                conflict_sticky <= 1'b0;

            if (conflict_ev && (conflict_count != '1))
                conflict_count <= conflict_count + CNT_W'(1);

            if (!arbitrate) begin
                state <= LOCKED;
            end else if (win_any) begin
                state        <= DRIVE;
                select       <= win_index;
                select_valid <= 1'b1;
                grant        <= NUM_SRC'(1) << win_index;
            end else begin
                state        <= IDLE;
                select_valid <= 1'b0;
                grant        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_select_encoder.sv
// Directed bench for bus_select_encoder: a reference model pushes expected
// outputs into a queue at drive time; they are popped and checked after the edge.
module tb_bus_select_encoder;

    localparam logic [31:0] MASK = 32'h02FF_FFFF;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] out_en = '0;
    logic        hold = 1'b0;
    logic        conflict_ack = 1'b0;
    logic [4:0]  select;
    logic        select_valid;
    logic [31:0] grant;
    logic        conflict;
    logic        conflict_sticky;
    logic        bad_req;
    logic [7:0]  conflict_count;

    bus_select_encoder dut (
        .clk             (clk),
        .clear           (clear),
        .out_en          (out_en),
        .hold            (hold),
        .conflict_ack    (conflict_ack),
        .select          (select),
        .select_valid    (select_valid),
        .grant           (grant),
        .conflict        (conflict),
        .conflict_sticky (conflict_sticky),
        .bad_req         (bad_req),
        .conflict_count  (conflict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  sel;
        logic        valid;
        logic [31:0] grant;
        logic        conf;
        logic        sticky;
        logic        bad;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference model state (0 = idle, 1 = drive, 2 = locked).
    int          m_state = 0;
    logic [4:0]  m_sel = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_grant = '0;
    logic        m_conf = 1'b0;
    logic        m_sticky = 1'b0;
    logic        m_bad = 1'b0;
    logic [7:0]  m_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic [31:0] oe, input logic h, input logic ack, input logic clr);
        logic [31:0] e;
        logic        ev;
        int          lowest;
        if (clr) begin
            m_state = 0; m_sel = '0; m_valid = 0; m_grant = '0;
            m_conf = 0; m_sticky = 0; m_bad = 0; m_cnt = '0;
            return;
        end
        e = oe & MASK;
        m_bad = (oe & ~MASK) != 0;
        ev = 1'b0;
        if (m_state != 0 && h) begin
            m_state = 2;
        end else if (e == 0) begin
            m_state = 0; m_valid = 0; m_grant = '0;
        end else begin
            lowest = -1;
            for (int i = 31; i >= 0; i--) if (e[i]) lowest = i;
            m_state = 1;
            m_sel   = 5'(lowest);
            m_valid = 1;
            m_grant = 32'd1 << lowest;
            ev = $countones(e) > 1;
        end
        m_conf = ev;
        if (ev) m_sticky = 1;
        else if (ack) m_sticky = 0;
        if (ev && m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic step(input logic [31:0] oe, input logic h, input logic ack, input logic clr);
        exp_t e;
        @(negedge clk);
        out_en = oe; hold = h; conflict_ack = ack; clear = clr;
        model(oe, h, ack, clr);
        e.sel = m_sel; e.valid = m_valid; e.grant = m_grant; e.conf = m_conf;
        e.sticky = m_sticky; e.bad = m_bad; e.cnt = m_cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            check("select",          32'(select),          32'(e.sel));
            check("select_valid",    32'(select_valid),    32'(e.valid));
            check("grant",           grant,                e.grant);
            check("conflict",        32'(conflict),        32'(e.conf));
            check("conflict_sticky", 32'(conflict_sticky), 32'(e.sticky));
            check("bad_req",         32'(bad_req),         32'(e.bad));
            check("conflict_count",  32'(conflict_count),  32'(e.cnt));
        end
    endtask

    initial begin
        // Reset with a pending request: clear dominates.
        step(32'h0000_0010, 0, 0, 1);
        step(32'h0000_0010, 0, 0, 1);
        check("rst_select", 32'(select), 32'd0);
        check("rst_valid", 32'(select_valid), 32'd0);
        check("rst_count", 32'(conflict_count), 32'd0);
        step(32'h0000_0010, 0, 0, 0);
        check("first_select", 32'(select), 32'd4);
        check("first_grant", grant, 32'h0000_0010);

        // Priority and conflict, then idle, then ack.
        step(32'h0000_0A00, 0, 0, 0);
        check("prio_select", 32'(select), 32'd9);
        check("prio_conflict", 32'(conflict), 32'd1);
        check("prio_count", 32'(conflict_count), 32'd1);
        step(32'h0, 0, 0, 0);
        check("idle_grant", grant, 32'h0);
        check("idle_sticky", 32'(conflict_sticky), 32'd1);
        step(32'h0, 0, 1, 0);
        check("ack_sticky", 32'(conflict_sticky), 32'd0);

        // Lock across a transfer; release re-arbitrates immediately.
        step(32'h0010_0000, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(32'h0000_000B, 1, 0, 0);
        check("lock_select", 32'(select), 32'd20);
        check("lock_no_conflict", 32'(conflict_count), 32'd1);
        step(32'h0000_0008, 0, 0, 0);
        check("release_select", 32'(select), 32'd3);

        // Unimplemented sources.
        step(32'h0100_0000, 0, 0, 0);
        check("bad_only_valid", 32'(select_valid), 32'd0);
        check("bad_only_select", 32'(select), 32'd3);
        check("bad_only_flag", 32'(bad_req), 32'd1);
        step(32'h8200_0000, 0, 0, 0);
        check("bad_mix_select", 32'(select), 32'd25);
        check("bad_mix_conflict", 32'(conflict), 32'd0);

        // Bad request while locked still pulses bad_req.
        step(32'h0000_0002, 1, 0, 0);
        step(32'h8000_0000, 1, 0, 0);
        check("locked_bad", 32'(bad_req), 32'd1);

        // Saturation.
        for (int i = 0; i < 300; i++) step(32'h0000_0003, 0, 0, 0);
        check("sat_count", 32'(conflict_count), 32'd255);
        step(32'h0000_0003, 0, 1, 0);
        check("ack_race_sticky", 32'(conflict_sticky), 32'd1);

        // Clear while locked.
        step(32'h0000_0002, 0, 0, 0);
        step(32'h0000_0004, 1, 0, 0);
        step(32'h0000_0004, 1, 0, 1);
        check("clr_lock_select", 32'(select), 32'd0);
        check("clr_lock_grant", grant, 32'h0);
        step(32'h0, 1, 0, 0);

        // Randomised mix of sparse requests, hold and ack.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] r;
            r = 32'd1 << $urandom_range(31, 0);
            if ($urandom_range(3, 0) == 0) r = r | (32'd1 << $urandom_range(31, 0));
            if ($urandom_range(4, 0) == 0) r = '0;
            step(r, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(19, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
